// File: rtl/rv_alu_iter.sv
// Execute-stage integer ALU with valid/ready handshakes and an iterative shifter.
// Define RV_ALU_FAST_SHIFT_EN for a single-cycle barrel shifter instead.
module rv_alu_iter #(
  parameter int XLEN       = 32,
  parameter int SHAMT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic            alt,
  input  logic            is_imm,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW:0] STEP = (SHW+1)'(SHAMT_STEP);

`ifdef RV_ALU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   sh_val;
  logic [SHW-1:0]    sh_cnt;
  logic              sh_left;
  logic              sh_arith;

  logic [SHW-1:0]    shamt;
  logic              is_shift;
  logic              accept;
  logic              lt_s;
  logic              lt_u;
  logic signed [XLEN-1:0] sra_in;
  logic [XLEN-1:0]   alu_res;

  logic [SHW:0]      cnt_w;
  logic [SHW:0]      step;
  logic [SHW:0]      cnt_rem;
  logic signed [XLEN-1:0] sra_it;
  logic [XLEN-1:0]   sh_next;

  assign in_ready  = (state == IDLE) ||
                     ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign busy      = (state == SHIFT);
  assign accept    = in_valid && in_ready;

  assign shamt    = src_b[SHW-1:0];
  assign is_shift = (funct3[1:0] == 2'b01);
  assign lt_s     = $signed(src_a) < $signed(src_b);
  assign lt_u     = src_a < src_b;
  assign sra_in   = $signed(src_a) >>> shamt;

  always_comb begin
    alu_res = '0;
    unique case (funct3)
      3'b000: alu_res = (!is_imm && alt) ?
                        src_a - src_b : src_a + src_b;
      3'b001: alu_res = FAST ? src_a << shamt : src_a;
      3'b010: alu_res = {{(XLEN-1){1'b0}}, lt_s};
      3'b011: alu_res = {{(XLEN-1){1'b0}}, lt_u};
      3'b100: alu_res = src_a ^ src_b;
      3'b101: begin
        if (!FAST)
          alu_res = src_a;
        else if (alt)
          alu_res = sra_in;
        else
          alu_res = src_a >> shamt;
      end
      3'b110: alu_res = src_a | src_b;
      3'b111: alu_res = src_a & src_b;
      default: alu_res = '0;
    endcase
  end

  // Last iteration may be shorter than SHAMT_STEP.
  assign cnt_w   = {1'b0, sh_cnt};
  assign step    = (cnt_w > STEP) ? STEP : cnt_w;
  assign cnt_rem = cnt_w - step;
  assign sra_it  = $signed(sh_val) >>> step;

  always_comb begin
    sh_next = sh_val >> step;
    if (sh_left)
      sh_next = sh_val << step;
    else if (sh_arith)
      sh_next = sra_it;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      out_result <= '0;
      sh_val     <= '0;
      sh_cnt     <= '0;
      sh_left    <= 1'b0;
      sh_arith   <= 1'b0;
    end else if (accept) begin
      if (!FAST && is_shift && (shamt != '0)) begin
        state    <= SHIFT;
        sh_val   <= src_a;
        sh_cnt   <= shamt;
        sh_left  <= !funct3[2];
        sh_arith <= alt;
      end else begin
        state      <= DONE;
        out_result <= alu_res;
      end
    end else if (state == SHIFT) begin
      sh_val <= sh_next;
      sh_cnt <= cnt_rem[SHW-1:0];
      if (cnt_rem == '0) begin
        state      <= DONE;
        out_result <= sh_next;
      end
    end else if ((state == DONE) && out_ready) begin
      state <= IDLE;
    end
  end

endmodule

// File: doc/rv_alu_iter.md
Name: rv_alu_iter

Overview:
- Parametrised integer ALU for R-type and I-type arithmetic/logic ops (ADD/SUB, SLT, SLTU, XOR, OR, AND, SLL, SRL, SRA).
- Sits in the execute stage between operand select and register-file writeback.
- Uses a valid/ready handshake on both input and output.
- Non-shift ops finish in one registered cycle; shifts run on an iterative shifter, SHAMT_STEP bits per cycle, to save area.

Parameters:
- XLEN, 32, operand/result width; must be 32 or 64.
- SHAMT_STEP, 1, bits shifted per iteration cycle; power of 2, 1..XLEN.
- SHW, $clog2(XLEN), shift-amount width (derived, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  unit can accept a request this cycle.
- funct3  in  3  instruction bits [14:12]: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
- alt  in  1  instruction bit [30]; selects SUB (R-type only) or SRA.
- is_imm  in  1  1 = I-type; forces ADD for funct3=000 regardless of alt.
- src_a  in  XLEN  rs1 value.
- src_b  in  XLEN  rs2 value or sign-extended immediate.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  XLEN  result.
- busy  out  1  high in SHIFT state.

Behaviour:
- Reset values: out_valid=0, out_result=0, busy=0, state=IDLE; in_ready=1 once reset is released.
- States:
  - IDLE: in_ready=1.
  - SHIFT: in_ready=0, busy=1.
  - DONE: out_valid=1, in_ready=out_ready.
- Accept: in_valid && in_ready. Operands, funct3, alt and is_imm are captured in the accept cycle.
- Non-shift op: result is computed from the captured inputs and registered in the accept cycle; DONE follows next cycle (latency 1).
- SLT is a signed compare, SLTU unsigned; both produce 1 or 0 zero-extended to XLEN.
- SUB only when is_imm=0 && alt=1.
- Shift op:
  - shamt = src_b[SHW-1:0]; upper bits of src_b are ignored.
  - shamt=0: DONE next cycle, result=src_a.
  - Otherwise enter SHIFT with remaining count = shamt.
  - Each SHIFT cycle shifts by min(SHAMT_STEP, remaining) and decrements the count.
  - Move to DONE when the count reaches 0.
  - Latency accept-to-out_valid = 1 + ceil(shamt/SHAMT_STEP).
- Shift type: alt=1 with funct3=101 is SRA (sign fill from bit XLEN-1); alt=0 is SRL (zero fill). alt is ignored for SLL.
- DONE state:
  - out_result is held stable until out_ready.
  - On out_ready with in_valid, the new op is accepted in the same cycle (back-to-back, no bubble) and DONE is re-entered or SHIFT entered as appropriate.
  - On out_ready without in_valid, return to IDLE and drop out_valid.
- out_valid and out_result change only on handshake completion or on a new result; no combinational path from in_* to out_*.
- Overflow wraps modulo 2^XLEN; no flags.
- rst_n asserted mid-SHIFT or mid-DONE: in-flight op is discarded immediately; the result is never presented.
- in_valid while in_ready=0: ignored; the requester must hold its inputs.

Optional Feature:
- Macro: RV_ALU_FAST_SHIFT_EN.
- Defined: shifts use a single-cycle barrel shifter; every op has latency 1; the SHIFT state is never entered; busy is tied 0; SHAMT_STEP is unused.
- Undefined: iterative shifter as described above.

Test Plan:
- ADD/SUB/SLT, XLEN=32, out_ready=1:
  - R-type SUB, src_a=5, src_b=7 -> out_result=0xFFFFFFFE one cycle after accept.
  - Same operands with is_imm=1, alt=1 -> 12.
  - SLT src_a=0xFFFFFFFF, src_b=1 -> 1; SLTU with the same operands -> 0.
- SRA/SRL, SHAMT_STEP=1:
  - SRA src_a=0x80000000, shamt 31 -> 0xFFFFFFFF; out_valid 32 cycles after accept; busy high for 31 cycles.
  - SRL with the same operands -> 0x00000001.
- SHAMT_STEP=4, SLL: src_a=1, src_b=0xFFFFFFE5 (shamt 5) -> 0x20 after 3 cycles. Shamt 0 -> result=src_a after 1 cycle.
- Backpressure: hold out_ready=0 for 5 cycles with XOR 0xF0F0^0xFF00 pending -> out_result=0x0FF0 stable and in_ready=0 throughout. Raise out_ready with in_valid (AND) -> accepted the same cycle; next result is valid the following cycle.
- Back-to-back stream of 8 ORI ops with out_ready=1 -> one result per cycle, in order, with no bubbles.
- Reset mid-shift: assert rst_n=0 during the 3rd SHIFT cycle -> out_valid=0, busy=0 immediately. After release, in_ready=1 and the next ADD completes correctly.
